// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/ready/result_valid handshake.
// Define MULDIV_RADIX4_EN to retire two bits per CALC cycle (XLEN/2 iterations) with identical results.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int AW    = 2 * XLEN;

`ifdef MULDIV_RADIX4_EN
  localparam int STEPS = XLEN / 2;
`else
  localparam int STEPS = XLEN;
`endif

  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state, next_state;
  logic [AW-1:0]     acc;        // {hi, lo}: product or {remainder, quotient}
  logic [AW-1:0]     acc_step;
  logic [XLEN-1:0]   b_mag;
  logic [2:0]        op;
  logic              neg;
  logic [CNT_W-1:0]  cnt;

  logic              a_neg, b_neg, div_zero, accept, last_iter;
  logic [XLEN-1:0]   a_abs, b_abs, zero_result, calc_result;
  logic [AW-1:0]     prod;
  logic [XLEN-1:0]   quo, rem;

  // One radix-2 iteration on magnitudes; multiply shifts right, divide shifts left.
  function automatic logic [AW-1:0] iterate(input logic is_div,
                                            input logic [AW-1:0] acc_in,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] hi, lo;
    logic [XLEN:0]   sum, shifted, diff;
    hi = acc_in[AW-1:XLEN];
    lo = acc_in[XLEN-1:0];
    if (is_div) begin
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, b};
      hi      = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo      = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      hi  = sum[XLEN:1];
      lo  = {sum[0], lo[XLEN-1:1]};
    end
    return {hi, lo};
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    a_neg       = 1'b0;
    b_neg       = 1'b0;
    if (func_3 == F_MULH || func_3 == F_MULHSU || func_3 == F_DIV || func_3 == F_REM)
      a_neg = operand_a[XLEN-1];
    if (func_3 == F_MULH || func_3 == F_DIV || func_3 == F_REM)
      b_neg = operand_b[XLEN-1];
    a_abs       = a_neg ? -operand_a : operand_a;
    b_abs       = b_neg ? -operand_b : operand_b;
    div_zero    = func_3[2] && (operand_b == '0);
    zero_result = func_3[1] ? operand_a : '1;
    accept      = (state == IDLE) && start && !flush;
    last_iter   = (cnt == CNT_W'(STEPS - 1));
  end

  always_comb begin
`ifdef MULDIV_RADIX4_EN
    acc_step = iterate(op[2], iterate(op[2], acc, b_mag), b_mag);
`else
    acc_step = iterate(op[2], acc, b_mag);
`endif
    prod = neg ? -acc_step : acc_step;
    quo  = neg ? -acc_step[XLEN-1:0]  : acc_step[XLEN-1:0];
    rem  = neg ? -acc_step[AW-1:XLEN] : acc_step[AW-1:XLEN];
    case (op)
      3'b000:                 calc_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_result = prod[AW-1:XLEN];
      3'b100, 3'b101:         calc_result = quo;
      default:                calc_result = rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = div_zero ? DONE : CALC;
      CALC:    if (last_iter) next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    ready        = (state == IDLE);
    result_valid = (state == DONE) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      b_mag  <= '0;
      op     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op    <= func_3;
        neg   <= (func_3[2] && func_3[1]) ? a_neg : (a_neg ^ b_neg);
        acc   <= {{XLEN{1'b0}}, a_abs};
        b_mag <= b_abs;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      // Only entering DONE updates result; flush blocks the transition and so keeps it.
      if (next_state == DONE)
        result <= (state == IDLE) ? zero_result : calc_result;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit, parametrised on XLEN; sits in EX beside the ALU.
- Decodes func_3 for the eight M-extension operations.
- Computes the result over multiple cycles with a start/ready/result_valid handshake.
- Hazard unit stalls the pipeline while ready is low; flush aborts an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; sampled only when ready=1.
- func_3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value (multiplicand/dividend).
- operand_b  input  XLEN  rs2 value (multiplier/divisor).
- flush  input  1  synchronous abort.
- ready  output  1  unit idle, can accept start.
- result_valid  output  1  one-cycle result strobe.
- result  output  XLEN  registered result.

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n sampled low at a clk edge.
- After the reset edge: state=IDLE, ready=1, result_valid=0, result=0, counter=0, internal datapath regs=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: ready=1. On start=1, latch func_3, operands and sign flags.
  - Divide op with operand_b==0: go to DONE (fast path).
  - Otherwise: go to CALC, counter=0.
- CALC: ready=0.
  - One iteration per cycle; go to DONE when counter reaches XLEN-1.
  - Multiply: shift-add on magnitudes, 2*XLEN product.
  - Divide: restoring, one quotient bit per cycle, on magnitudes.
- DONE: ready=0, result_valid=1 for exactly one cycle, result loaded at entry; next state IDLE.
- Latency: start in cycle 0 -> CALC in cycles 1..XLEN -> result_valid in cycle XLEN+1 -> ready=1 in cycle XLEN+2. Divide-by-zero: result_valid in cycle 1.
- result holds its value after DONE until the next DONE. It does not change on start, flush or IDLE.
- Sign handling:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
  - Negate magnitude result if operand signs differ (quotient) or dividend negative (remainder).
- Result selection: MUL low XLEN bits; MULH* high XLEN bits; DIV* quotient; REM* remainder.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_a.
- Signed overflow (DIV -2^(XLEN-1) / -1): quotient=-2^(XLEN-1), remainder=0. Falls out of magnitude arithmetic; no special case needed.
- start while ready=0: ignored, no queuing.
- Operand changes after acceptance: no effect.
- flush=1 in any state: next state IDLE, no result_valid (including when flush and DONE coincide, which suppresses the strobe), result unchanged. flush together with start in IDLE: start dropped.
- Reset mid-operation: same as flush, plus result cleared to 0.

Optional Feature:
- Macro: MULDIV_RADIX4_EN.
- Defined:
  - CALC retires two bits per cycle (radix-4 shift-add; two chained restoring steps).
  - CALC lasts XLEN/2 cycles; result_valid in cycle XLEN/2+1.
  - Results identical to the undefined case.
- Undefined: radix-2, XLEN CALC cycles.
- Divide-by-zero fast path and flush behaviour are the same in both builds.

Test Plan (XLEN=32, radix-2 unless noted):
- MUL a=7, b=0xFFFFFFFD (-3), start cycle 0 -> ready=0 cycles 1..33; result_valid=1 only in cycle 33; result=0xFFFFFFEB; ready=1 cycle 34.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> result_valid cycle 1, result 0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Abort and ignore:
  - MUL started cycle 0, flush cycle 10 -> ready=1 cycle 11, no result_valid, result keeps previous value.
  - start pulsed cycle 5 while busy -> ignored.
  - rst_n low cycle 12 -> result=0, ready=1 next cycle.
- MULDIV_RADIX4_EN defined: MUL 7*-3 -> result_valid cycle 17, result 0xFFFFFFEB; DIVU 100/7 -> 14 at cycle 17.
